game_tick_gen: RTL

- Parametrised game-timing generator. Successor to the fixed free-running score divider.
- Produces single-cycle score and obstacle tick pulses from the 27 MHz system clock.
- Gated by game state, with pause support. Keeps a running score and difficulty level, and shortens the obstacle period as the score rises.
- Sits between the game-state FSM and the score display / obstacle spawner.

---
 rtl/game_tick_gen.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/game_tick_gen.sv
// game_tick_gen
//   Game-timing generator. Produces one-cycle score and obstacle tick pulses
//   from the system clock. The pulses are gated by the game state and by
//   pause. The block also keeps a running score and a difficulty level, and
//   shortens the obstacle period as the score rises.
//
//   Optional build macro: GAME_TICK_SCORE_BCD_EN
//     Defined   : score is 4-digit packed BCD (SCORE_W must be 16) and
//                 saturates at 16'h9999.
//     Undefined : score is plain binary and saturates at all-ones.
//
// Ports
//   clk           in   system clock (27 MHz)
//   rst_n         in   asynchronous active-low reset
//   gameon        in   high while the game is in its play state
//   pause         in   freeze timing while high
//   score_tick    out  one-cycle pulse per score increment
//   obstacle_tick out  one-cycle pulse per obstacle spawn request
//   score         out  current score (binary or BCD)
//   level         out  difficulty level 0..15
//   obst_period   out  current obstacle divisor
//   running       out  high while in RUN
module game_tick_gen #(
   parameter int unsigned SCORE_DIV     = 1000000,
   parameter int unsigned OBST_DIV_INIT = 13500000,
   parameter int unsigned OBST_DIV_MIN  = 4500000,
   parameter int unsigned SPEEDUP_STEP  = 900000,
   parameter int unsigned SPEEDUP_EVERY = 50,
   parameter int unsigned CNT_W         = 24,
   parameter int unsigned SCORE_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               gameon,
   input  logic               pause,
   output logic               score_tick,
   output logic               obstacle_tick,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         level,
   output logic [CNT_W-1:0]   obst_period,
   output logic               running
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   localparam int unsigned SPD_W = (SPEEDUP_EVERY < 2) ? 1 : $clog2(SPEEDUP_EVERY);

   localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]   SCORE_LAST  = CNT_W'(SCORE_DIV - 1);
   localparam logic [CNT_W-1:0]   OBST_INIT_C = CNT_W'(OBST_DIV_INIT);
   localparam logic [CNT_W-1:0]   OBST_MIN_C  = CNT_W'(OBST_DIV_MIN);
   localparam logic [CNT_W-1:0]   STEP_C      = CNT_W'(SPEEDUP_STEP);
   // Threshold is one bit wider so MIN+STEP cannot wrap.
   localparam logic [CNT_W:0]     SPEED_THR   = (CNT_W+1)'(OBST_DIV_MIN + SPEEDUP_STEP);
   localparam logic [SPD_W-1:0]   SPD_ZERO    = {SPD_W{1'b0}};
   localparam logic [SPD_W-1:0]   SPD_LAST    = SPD_W'(SPEEDUP_EVERY - 1);
   localparam logic [SCORE_W-1:0] SCORE_ZERO  = {SCORE_W{1'b0}};
`ifdef GAME_TICK_SCORE_BCD_EN
   localparam logic [SCORE_W-1:0] SCORE_MAX   = {(SCORE_W/4){4'h9}};
`else
   localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
`endif

   // Saturating score increment. In BCD mode a decimal carry ripples through
   // every digit within the same cycle.
   function automatic logic [SCORE_W-1:0] score_inc_f(input logic [SCORE_W-1:0] val);
      logic [SCORE_W-1:0] res;
`ifdef GAME_TICK_SCORE_BCD_EN
      logic carry;
      res   = val;
      carry = 1'b1;
      if (val == SCORE_MAX) begin
         res = val;
      end else begin
         for (int i = 0; i < int'(SCORE_W / 4); i++) begin
            if (carry) begin
               if (val[4*i +: 4] == 4'd9) begin
                  res[4*i +: 4] = 4'd0;
               end else begin
                  res[4*i +: 4] = val[4*i +: 4] + 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
`else
      if (val == SCORE_MAX) begin
         res = val;
      end else begin
         res = val + SCORE_W'(1);
      end
`endif
      return res;
   endfunction

   state_t             state_r, state_nxt_s;
   logic [CNT_W-1:0]   score_cnt_r, obst_cnt_r, obst_period_r;
   logic [SPD_W-1:0]   spd_cnt_r;
   logic [SCORE_W-1:0] score_r;
   logic [3:0]         level_r;
   logic               score_tick_r, obstacle_tick_r, running_r;
   logic               start_s, advance_s, score_wrap_s, obst_wrap_s, speed_wrap_s;
   logic [CNT_W-1:0]   period_dec_s;

   // Next-state selection; gameon low wins over pause.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (gameon) state_nxt_s = ST_RUN;
            else        state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (!gameon)    state_nxt_s = ST_IDLE;
            else if (pause) state_nxt_s = ST_PAUSED;
            else            state_nxt_s = ST_RUN;
         end
         ST_PAUSED: begin
            if (!gameon)     state_nxt_s = ST_IDLE;
            else if (!pause) state_nxt_s = ST_RUN;
            else             state_nxt_s = ST_PAUSED;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Count enables and wrap detection. Counting also happens on the cycle
   // that leaves PAUSED, so the time lost equals the cycles pause was high.
   always_comb begin
      start_s      = (state_r == ST_IDLE) && gameon;
      advance_s    = (state_r != ST_IDLE) && gameon && !pause;
      score_wrap_s = advance_s && (score_cnt_r == SCORE_LAST);
      // >= keeps a freshly shortened period from skipping a tick.
      obst_wrap_s  = advance_s && (obst_cnt_r >= (obst_period_r - CNT_ONE));
      speed_wrap_s = score_wrap_s && (spd_cnt_r == SPD_LAST);
      // Compare before subtracting so the period never underflows.
      if ({1'b0, obst_period_r} >= SPEED_THR) begin
         period_dec_s = obst_period_r - STEP_C;
      end else begin
         period_dec_s = OBST_MIN_C;
      end
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= ST_IDLE;
         score_cnt_r     <= CNT_ZERO;
         obst_cnt_r      <= CNT_ZERO;
         spd_cnt_r       <= SPD_ZERO;
         obst_period_r   <= OBST_INIT_C;
         score_r         <= SCORE_ZERO;
         level_r         <= 4'd0;
         score_tick_r    <= 1'b0;
         obstacle_tick_r <= 1'b0;
         running_r       <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         running_r       <= (state_nxt_s == ST_RUN);
         score_tick_r    <= score_wrap_s;
         obstacle_tick_r <= obst_wrap_s;
         if (start_s) begin
            score_cnt_r   <= CNT_ZERO;
            obst_cnt_r    <= CNT_ZERO;
            spd_cnt_r     <= SPD_ZERO;
            obst_period_r <= OBST_INIT_C;
            score_r       <= SCORE_ZERO;
            level_r       <= 4'd0;
         end else if (!gameon) begin
            // Leaving play (or idling): counters clear, score/level held.
            score_cnt_r <= CNT_ZERO;
            obst_cnt_r  <= CNT_ZERO;
            spd_cnt_r   <= SPD_ZERO;
         end else if (advance_s) begin
            score_cnt_r <= score_wrap_s ? CNT_ZERO : (score_cnt_r + CNT_ONE);
            obst_cnt_r  <= obst_wrap_s  ? CNT_ZERO : (obst_cnt_r + CNT_ONE);
            if (score_wrap_s) begin
               score_r   <= score_inc_f(score_r);
               spd_cnt_r <= speed_wrap_s ? SPD_ZERO : (spd_cnt_r + SPD_W'(1));
            end
            if (speed_wrap_s) begin
               obst_period_r <= period_dec_s;
               if (level_r != 4'hF) begin
                  level_r <= level_r + 4'd1;
               end
            end
         end
      end
   end

   assign score_tick    = score_tick_r;
   assign obstacle_tick = obstacle_tick_r;
   assign score         = score_r;
   assign level         = level_r;
   assign obst_period   = obst_period_r;
   assign running       = running_r;

endmodule
